health_damage_ctrl: RTL and testbench
=====================================

// Module: health_damage_ctrl
// PURPOSE
//  Arbitrates hit requests from NUM_SRC damage sources (enemies, projectiles) and sequences
//  the player health counter: one damage point per granted hit, an invulnerability window
//  after each hit, and a game-over state at zero health. Sits between collision logic and
//  the HUD/VGA draw logic; replaces the single-bit health flag with a multi-point counter.
// PARAMETERS
//  NUM_SRC     4    number of hit requesters
//  HP_W        4    width of health counter
//  MAX_HP      3    health loaded on reset/start; must fit HP_W, must be >=1
//  IFRAME_CYC  16   invulnerability window length, cycles (>=1)
//  REGEN_CYC   64   idle cycles per regen point (used only with HEALTH_REGEN_EN)
// PORTS
//  clk         in   1        system clock
//  rst         in   1        reset, asynchronous, active-low
//  start       in   1        one-cycle pulse: begin/restart game
//  hit_req     in   NUM_SRC  level request per source, held until acked
//  hit_ack     out  NUM_SRC  one-hot one-cycle pulse: request consumed (granted or discarded)
//  health      out  HP_W     current health points
//  alive       out  1        1 in ARMED or INVULN
//  invuln      out  1        1 in INVULN
//  hit_pulse   out  1        one-cycle pulse when damage is applied
//  game_over   out  1        1 in DEAD
// BEHAVIOUR
//  Reset (rst=0): state IDLE, health=MAX_HP, rr pointer=0, all other outputs 0, timers 0.
//  All outputs registered. States: IDLE, ARMED, INVULN, DEAD.
//  IDLE:   start -> ARMED, health<=MAX_HP. Pending requests acked-and-discarded, no damage.
//  ARMED:  any hit_req -> round-robin grant of exactly one source (search begins at rr+1 after
//          last grant); next edge: hit_ack[g]=1, hit_pulse=1, health-1, rr<=g.
//          If health-1==0 -> DEAD, else -> INVULN with iframe counter loaded IFRAME_CYC-1.
//          Non-granted simultaneous requests stay un-acked this cycle.
//          start ignored.
//  INVULN: counter decrements each cycle; at 0 -> ARMED. Requests acked-and-discarded,
//          one source per cycle (round-robin); health unchanged, hit_pulse=0. start ignored.
//  DEAD:   health=0, game_over=1; requests acked-and-discarded. start -> ARMED, health<=MAX_HP,
//          rr<=0.
//  Latency: hit_req sampled at edge N -> hit_ack/health/hit_pulse/state valid after edge N.
//  Health never underflows (saturates at 0, DEAD entered same edge as reaching 0).
//  hit_ack never asserted for a source whose hit_req is 0; at most one bit set per cycle.
//  Async reset mid-INVULN or mid-regen: all counters cleared, IDLE.
// CONFIGURATION
//  HEALTH_REGEN_EN defined: in ARMED a regen counter counts cycles since last damage/regen;
//    at REGEN_CYC with health<MAX_HP -> health+1, counter restarts. Counter cleared on hit,
//    on leaving ARMED, on start. Damage and regen in same cycle: damage wins, no regen.
//    Health never exceeds MAX_HP.
//  Undefined: no regen logic; health only decreases or reloads on start.
// STRUCTURE
//  Package health_pkg: state enum (IDLE/ARMED/INVULN/DEAD), default MAX_HP/IFRAME_CYC consts.
//  Sub-module rr_arbiter (NUM_SRC req in, one-hot grant out, pointer update on accept);
//  FSM, health counter, iframe and regen timers in top.
// TESTING
//  1 reset, start pulse -> health=3, alive=1, game_over=0, hit_ack=0.
//  2 ARMED, hit_req=4'b0001 one cycle -> hit_ack=0001, health=2, invuln=1 for 16 cycles, then ARMED.
//  3 ARMED, hit_req=4'b1010 held -> ack 0010 with damage, then 1000 acked in INVULN, health=2.
//  4 three hits spaced >16 cycles apart -> health 2,1,0; game_over=1; start -> health=3, ARMED.
//  5 rst low mid-INVULN -> IDLE, health=3, invuln=0; hit_req in IDLE acked, health unchanged.
//  6 HEALTH_REGEN_EN: health=2, no hits 64 cycles -> health=3; further 64 cycles -> stays 3.

Source files
------------

// File: rtl/health_pkg.sv
// Shared state encoding and default sizing for the health/damage controller.
package health_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_HP_W       = 4;
  localparam int DEF_MAX_HP     = 3;
  localparam int DEF_IFRAME_CYC = 16;
  localparam int DEF_REGEN_CYC  = 64;

endpackage

// File: rtl/health_damage_ctrl_if.sv
// Bus between collision logic (master) and the health/damage controller (slave).
interface health_damage_ctrl_if
  import health_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int HP_W    = DEF_HP_W
);

  logic               start;
  logic [NUM_SRC-1:0] hit_req;
  logic [NUM_SRC-1:0] hit_ack;
  logic [HP_W-1:0]    health;
  logic               alive;
  logic               invuln;
  logic               hit_pulse;
  logic               game_over;

  modport master (
    output start, hit_req,
    input  hit_ack, health, alive, invuln, hit_pulse, game_over
  );

  modport slave (
    input  start, hit_req,
    output hit_ack, health, alive, invuln, hit_pulse, game_over
  );

endinterface

// File: rtl/health_damage_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last accepted source.
module rr_arbiter
  import health_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               accept,
  input  logic               clear,
  output logic [NUM_SRC-1:0] grant
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NUM_SRC);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Restart clears the pointer even if a grant is issued in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (accept && found) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/health_damage_ctrl.sv
// Player health sequencer: arbitrated damage, invulnerability window, game over.
// Optional passive regeneration in ARMED is enabled by defining HEALTH_REGEN_EN.
module health_damage_ctrl
  import health_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int HP_W       = DEF_HP_W,
  parameter int MAX_HP     = DEF_MAX_HP,
  parameter int IFRAME_CYC = DEF_IFRAME_CYC,
  parameter int REGEN_CYC  = DEF_REGEN_CYC
) (
  input logic                clk,
  input logic                rst,
  health_damage_ctrl_if.slave bus
);

  localparam int IF_W = $clog2(IFRAME_CYC + 1);

  if (MAX_HP < 1 || MAX_HP >= (1 << HP_W)) begin : g_bad_max_hp
    $error("MAX_HP must be >= 1 and fit in HP_W bits");
  end
  if (IFRAME_CYC < 1 || REGEN_CYC < 1) begin : g_bad_timers
    $error("IFRAME_CYC and REGEN_CYC must be >= 1");
  end

  state_t             state;
  state_t             state_nxt;
  logic [HP_W-1:0]    health_q;
  logic [IF_W-1:0]    iframe_cnt;
  logic [NUM_SRC-1:0] hit_ack_q;
  logic               hit_pulse_q;
  logic               alive_q;
  logic               invuln_q;
  logic               game_over_q;
  logic [NUM_SRC-1:0] req_eff;
  logic [NUM_SRC-1:0] grant;
  logic               any_grant;
  logic               rr_clear;

`ifdef HEALTH_REGEN_EN
  localparam int RG_W = $clog2(REGEN_CYC + 1);
  logic [RG_W-1:0] regen_cnt;
`endif

  // A source acked last cycle may still be holding its request; it is already consumed.
  assign req_eff   = bus.hit_req & ~hit_ack_q;
  assign any_grant = |grant;
  assign rr_clear  = (state == DEAD) && bus.start;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_eff),
    .accept (any_grant),
    .clear  (rr_clear),
    .grant  (grant)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ARMED;
      ARMED:   if (any_grant) state_nxt = (health_q <= HP_W'(1)) ? DEAD : INVULN;
      INVULN:  if (iframe_cnt == '0) state_nxt = ARMED;
      DEAD:    if (bus.start) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // Every request seen outside a damage grant is acked and discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      health_q    <= HP_W'(MAX_HP);
      iframe_cnt  <= '0;
      hit_ack_q   <= '0;
      hit_pulse_q <= 1'b0;
      alive_q     <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
`ifdef HEALTH_REGEN_EN
      regen_cnt   <= '0;
`endif
    end else begin
      state       <= state_nxt;
      hit_ack_q   <= grant;
      hit_pulse_q <= 1'b0;
      alive_q     <= (state_nxt == ARMED) || (state_nxt == INVULN);
      invuln_q    <= (state_nxt == INVULN);
      game_over_q <= (state_nxt == DEAD);
`ifdef HEALTH_REGEN_EN
      regen_cnt   <= '0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) health_q <= HP_W'(MAX_HP);
        end
        ARMED: begin
          if (any_grant) begin
            hit_pulse_q <= 1'b1;
            health_q    <= (health_q == '0) ? '0 : health_q - 1'b1;
            iframe_cnt  <= IF_W'(IFRAME_CYC - 1);
          end
`ifdef HEALTH_REGEN_EN
          else if (regen_cnt == RG_W'(REGEN_CYC - 1)) begin
            if (health_q < HP_W'(MAX_HP)) health_q <= health_q + 1'b1;
          end else begin
            regen_cnt <= regen_cnt + 1'b1;
          end
`endif
        end
        INVULN: begin
          if (iframe_cnt != '0) iframe_cnt <= iframe_cnt - 1'b1;
        end
        DEAD: begin
          health_q <= bus.start ? HP_W'(MAX_HP) : '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.hit_ack   = hit_ack_q;
  assign bus.health    = health_q;
  assign bus.alive     = alive_q;
  assign bus.invuln    = invuln_q;
  assign bus.hit_pulse = hit_pulse_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_health_damage_ctrl.sv
// Scoreboard bench for health_damage_ctrl; expected acks are queued when requests are driven.
module tb_health_damage_ctrl;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] health;
    logic       pulse;
  } exp_t;

`ifdef HEALTH_REGEN_EN
  localparam logic [3:0] REGEN_HP = 4'd3;
`else
  localparam logic [3:0] REGEN_HP = 4'd2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_level = '0;
  logic [3:0] consumed  = '0;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;

  health_damage_ctrl_if #(.NUM_SRC(4), .HP_W(4)) bus ();

  health_damage_ctrl #(
    .NUM_SRC    (4),
    .HP_W       (4),
    .MAX_HP     (3),
    .IFRAME_CYC (16),
    .REGEN_CYC  (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // A source drops its request once it has seen the ack for it.
  assign bus.hit_req = req_level & ~consumed;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expect_ack(input logic [3:0] ack, input logic [3:0] health, input logic pulse);
    exp_t e;
    e.ack = ack;
    e.health = health;
    e.pulse = pulse;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [3:0] req, input bit one_cycle);
    @(negedge clk);
    req_level = req;
    if (one_cycle) begin
      @(negedge clk);
      req_level = '0;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_armed(input string tag);
    int n;
    n = 0;
    while (bus.invuln !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, bus.invuln, 1'b0);
  endtask

  task automatic start_game();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst === 1'b1) begin
      if (bus.hit_ack != '0) begin
        check_output("ack_onehot", 32'($onehot(bus.hit_ack)), 32'd1);
        if (sb.size() == 0) begin
          check_output("unexpected_ack", bus.hit_ack, 4'b0000);
        end else begin
          e = sb.pop_front();
          check_output("sb_ack", bus.hit_ack, e.ack);
          check_output("sb_health", bus.health, e.health);
          check_output("sb_pulse", bus.hit_pulse, e.pulse);
        end
      end else begin
        check_output("pulse_without_ack", bus.hit_pulse, 1'b0);
      end
    end
    consumed = (consumed | bus.hit_ack) & req_level;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    bus.start = 1'b0;
    wait_cycles(3);
    check_output("rst_health", bus.health, 4'd3);
    check_output("rst_alive", bus.alive, 1'b0);
    check_output("rst_game_over", bus.game_over, 1'b0);
    check_output("rst_hit_ack", bus.hit_ack, 4'b0000);
    check_output("rst_invuln", bus.invuln, 1'b0);
    rst = 1'b1;

    // Start: armed at full health.
    start_game();
    check_output("t1_health", bus.health, 4'd3);
    check_output("t1_alive", bus.alive, 1'b1);
    check_output("t1_game_over", bus.game_over, 1'b0);
    check_output("t1_hit_ack", bus.hit_ack, 4'b0000);

    // Single hit and the full invulnerability window.
    expect_ack(4'b0001, 4'd2, 1'b1);
    apply_stimulus(4'b0001, 1'b1);
    check_output("t2_invuln", bus.invuln, 1'b1);
    n = 0;
    while (bus.invuln === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_output("t2_iframe_len", n, 16);
    check_output("t2_alive", bus.alive, 1'b1);

    // Fresh game, two simultaneous held requests.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start_game();
    expect_ack(4'b0010, 4'd2, 1'b1);
    expect_ack(4'b1000, 4'd2, 1'b0);
    apply_stimulus(4'b1010, 1'b0);
    wait_cycles(4);
    req_level = '0;
    wait_armed("t3_armed");
    check_output("t3_health", bus.health, 4'd2);

    // Asynchronous reset in the middle of the window, then a request while idle.
    expect_ack(4'b0100, 4'd1, 1'b1);
    apply_stimulus(4'b0100, 1'b1);
    wait_cycles(4);
    rst = 1'b0;
    #1;
    check_output("t5_health", bus.health, 4'd3);
    check_output("t5_invuln", bus.invuln, 1'b0);
    check_output("t5_alive", bus.alive, 1'b0);
    check_output("t5_hit_ack", bus.hit_ack, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    expect_ack(4'b0001, 4'd3, 1'b0);
    apply_stimulus(4'b0001, 1'b0);
    wait_cycles(3);
    req_level = '0;
    check_output("t5_idle_health", bus.health, 4'd3);
    check_output("t5_idle_alive", bus.alive, 1'b0);

    // Three spaced hits drain health to zero.
    start_game();
    for (int i = 0; i < 3; i++) begin
      expect_ack(4'b0100, 4'(2 - i), 1'b1);
      apply_stimulus(4'b0100, 1'b1);
      if (i < 2) wait_armed("t4_armed");
      wait_cycles(3);
    end
    check_output("t4_game_over", bus.game_over, 1'b1);
    check_output("t4_alive", bus.alive, 1'b0);
    check_output("t4_health", bus.health, 4'd0);
    check_output("t4_invuln", bus.invuln, 1'b0);
    expect_ack(4'b0010, 4'd0, 1'b0);
    apply_stimulus(4'b0010, 1'b1);
    wait_cycles(2);
    check_output("t4_dead_health", bus.health, 4'd0);
    start_game();
    check_output("t4_restart_health", bus.health, 4'd3);
    check_output("t4_restart_alive", bus.alive, 1'b1);
    check_output("t4_restart_game_over", bus.game_over, 1'b0);

    // All sources at once: one damage, the rest discarded in rotation.
    expect_ack(4'b0010, 4'd2, 1'b1);
    expect_ack(4'b0100, 4'd2, 1'b0);
    expect_ack(4'b1000, 4'd2, 1'b0);
    expect_ack(4'b0001, 4'd2, 1'b0);
    apply_stimulus(4'b1111, 1'b0);
    wait_cycles(6);
    req_level = '0;
    wait_armed("rr_armed");
    check_output("rr_health", bus.health, 4'd2);

    // Idle time in ARMED: regenerates only when the feature is built in.
    wait_cycles(70);
    check_output("t6_regen_first", bus.health, REGEN_HP);
    wait_cycles(70);
    check_output("t6_regen_cap", bus.health, REGEN_HP);

    check_output("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
